// File: rtl/fp_pair_mem_sequencer_if.sv
// Request, memory and register-file bundle for the FP load/store
// pair sequencer; slave is the sequencer, master is its environment.
interface fp_pair_mem_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [31:0] req_addr;
    logic [4:0]  req_freg;
    logic [31:0] st_data_lo;
    logic [31:0] st_data_hi;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [4:0]  rf_write_reg;
    logic [31:0] rf_wdata1;
    logic [31:0] rf_wdata2;
    logic        rf_reg_write;
    logic        rf_reg_dwrite;
    logic        done;
    logic        err;

    modport slave (
        input  req_valid, req_op, req_addr, req_freg,
        input  st_data_lo, st_data_hi,
        input  mem_ack, mem_rdata,
        output req_ready,
        output mem_req, mem_we, mem_addr, mem_wdata,
        output rf_write_reg, rf_wdata1, rf_wdata2,
        output rf_reg_write, rf_reg_dwrite,
        output done, err
    );

    modport master (
        output req_valid, req_op, req_addr, req_freg,
        output st_data_lo, st_data_hi,
        output mem_ack, mem_rdata,
        input  req_ready,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        input  rf_write_reg, rf_wdata1, rf_wdata2,
        input  rf_reg_write, rf_reg_dwrite,
        input  done, err
    );
endinterface

// File: rtl/fp_pair_mem_sequencer.sv
// Sequences LWC1/LDC1/SWC1/SDC1 between the 32-bit data port and the
// FP register file; doubles become two word accesses to an even/odd pair.
module fp_pair_mem_sequencer (
    input  logic                            clk,
    input  logic                            rst_n,
    fp_pair_mem_sequencer_if.slave          bus
);

    typedef enum logic [2:0] {
        IDLE,
        ACC0,
        ACC1,
        WB,
        DONE,
        ERR
    } state_t;

    state_t      state;
    logic        isDouble;
    logic        isStore;
    logic [31:0] addrReg;
    logic [4:0]  fregReg;
    logic [31:0] loReg;
    logic [31:0] hiReg;
    logic        reqBad;

    // Misaligned words, misaligned doubles and odd pair bases are rejected.
    assign reqBad = bus.req_op[0]
                  ? ((bus.req_addr[2:0] != 3'd0) | bus.req_freg[0])
                  : (bus.req_addr[1:0] != 2'd0);

    // Ready is held low throughout reset so nothing is accepted then.
    assign bus.req_ready = (state == IDLE) & rst_n;

    // Request FSM; every bus and register-file output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= IDLE;
            isDouble          <= 1'b0;
            isStore           <= 1'b0;
            addrReg           <= 32'd0;
            fregReg           <= 5'd0;
            loReg             <= 32'd0;
            hiReg             <= 32'd0;
            bus.mem_req       <= 1'b0;
            bus.mem_we        <= 1'b0;
            bus.mem_addr      <= 32'd0;
            bus.mem_wdata     <= 32'd0;
            bus.rf_write_reg  <= 5'd0;
            bus.rf_wdata1     <= 32'd0;
            bus.rf_wdata2     <= 32'd0;
            bus.rf_reg_write  <= 1'b0;
            bus.rf_reg_dwrite <= 1'b0;
            bus.done          <= 1'b0;
            bus.err           <= 1'b0;
        end else begin
            bus.done          <= 1'b0;
            bus.err           <= 1'b0;
            bus.rf_reg_write  <= 1'b0;
            bus.rf_reg_dwrite <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        isDouble <= bus.req_op[0];
                        isStore  <= bus.req_op[1];
                        addrReg  <= bus.req_addr;
                        fregReg  <= bus.req_freg;
                        loReg    <= bus.st_data_lo;
                        hiReg    <= bus.st_data_hi;
                        if (reqBad) begin
                            state    <= ERR;
                            bus.done <= 1'b1;
                            bus.err  <= 1'b1;
                        end else begin
                            state         <= ACC0;
                            bus.mem_req   <= 1'b1;
                            bus.mem_we    <= bus.req_op[1];
                            bus.mem_addr  <= bus.req_addr;
                            bus.mem_wdata <= bus.st_data_lo;
                        end
                    end
                end
                ACC0: begin
                    if (bus.mem_ack) begin
                        if (!isStore) begin
                            loReg <= bus.mem_rdata;
                        end
                        if (isDouble) begin
                            state         <= ACC1;
                            bus.mem_addr  <= addrReg + 32'd4;
                            bus.mem_wdata <= hiReg;
                        end else begin
                            bus.mem_req <= 1'b0;
                            bus.mem_we  <= 1'b0;
                            if (isStore) begin
                                state    <= DONE;
                                bus.done <= 1'b1;
                            end else begin
                                state            <= WB;
                                bus.rf_write_reg <= fregReg;
                                bus.rf_wdata1    <= bus.mem_rdata;
                                bus.rf_wdata2    <= 32'd0;
                                bus.rf_reg_write <= 1'b1;
                            end
                        end
                    end
                end
                ACC1: begin
                    if (bus.mem_ack) begin
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                        if (isStore) begin
                            state    <= DONE;
                            bus.done <= 1'b1;
                        end else begin
                            state             <= WB;
                            hiReg             <= bus.mem_rdata;
                            bus.rf_write_reg  <= fregReg;
                            bus.rf_wdata1     <= loReg;
                            bus.rf_wdata2     <= bus.mem_rdata;
                            bus.rf_reg_dwrite <= 1'b1;
                        end
                    end
                end
                WB: begin
                    state    <= DONE;
                    bus.done <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_pair_mem_sequencer.sv
// Bench for fp_pair_mem_sequencer: directed scenarios plus random
// requests checked against a transaction-level model and a word memory.
module tb_fp_pair_mem_sequencer;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fp_pair_mem_sequencer_if bus();

    fp_pair_mem_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        dw;
    } rfw_t;

    int checks = 0;
    int errors = 0;

    logic [31:0] memArr [logic [31:0]];
    acc_t        accLog[$];
    rfw_t        rfLog[$];
    int          waitQ[$];

    bit   inAccess = 1'b0;
    int   waitsLeft = 0;
    acc_t cur;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        if (memArr.exists(a)) return memArr[a];
        return {a[15:0], ~a[15:0]} ^ 32'hC3C3_1234;
    endfunction

    // Word memory: per-access wait states from waitQ, ack noise when idle.
    always @(negedge clk) begin
        if (bus.mem_req === 1'b1) begin
            if (!inAccess) begin
                inAccess  = 1'b1;
                cur.addr  = bus.mem_addr;
                cur.we    = bus.mem_we;
                cur.wdata = bus.mem_wdata;
                waitsLeft = (waitQ.size() > 0) ? waitQ.pop_front() : 0;
            end else begin
                checks++;
                if (bus.mem_addr !== cur.addr || bus.mem_we !== cur.we ||
                    bus.mem_wdata !== cur.wdata) begin
                    errors++;
                    $display("FAIL mem_hold: addr=%h we=%b wdata=%h, required %h %b %h",
                             bus.mem_addr, bus.mem_we, bus.mem_wdata,
                             cur.addr, cur.we, cur.wdata);
                end
            end
            if (waitsLeft > 0) begin
                waitsLeft--;
                bus.mem_ack   = 1'b0;
                bus.mem_rdata = $urandom;
            end else begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = memRead(cur.addr);
                if (cur.we) memArr[cur.addr] = cur.wdata;
                accLog.push_back(cur);
                inAccess = 1'b0;
            end
        end else begin
            inAccess      = 1'b0;
            bus.mem_ack   = 1'($urandom_range(0, 1));
            bus.mem_rdata = $urandom;
        end
    end

    // Register-file port monitor.
    always @(negedge clk) begin
        if (bus.rf_reg_write === 1'b1 || bus.rf_reg_dwrite === 1'b1) begin
            checks++;
            if (bus.rf_reg_write === 1'b1 && bus.rf_reg_dwrite === 1'b1) begin
                errors++;
                $display("FAIL rf_both: write=1 dwrite=1, required only one");
            end
            rfLog.push_back('{bus.rf_write_reg, bus.rf_wdata1,
                              bus.rf_wdata2, bus.rf_reg_dwrite});
        end
    end

    // Issues one request at the current negedge and checks the whole
    // transaction; returns at the negedge after done.
    task automatic runReq(input string name, input logic [1:0] op,
                          input logic [31:0] addr, input logic [4:0] freg,
                          input logic [31:0] lo, input logic [31:0] hi,
                          input int w0, input int w1);
        bit          dbl;
        bit          st;
        bit          bad;
        int          expLat;
        logic [31:0] e0;
        logic [31:0] e1;
        acc_t        expAcc[$];
        bit          seen;
        int          lat;
        logic        gotErr;
        int          n;
        dbl = op[0];
        st  = op[1];
        bad = dbl ? (addr[2:0] != 3'd0 || freg[0]) : (addr[1:0] != 2'd0);
        e0  = memRead(addr);
        e1  = memRead(addr + 32'd4);
        if (!bad) begin
            expAcc.push_back('{addr, st, lo});
            if (dbl) expAcc.push_back('{addr + 32'd4, st, hi});
        end
        expLat = 1;
        if (!bad) begin
            expLat += 1 + w0;
            if (dbl) expLat += 1 + w1;
            if (!st) expLat += 1;
        end
        waitQ.delete();
        accLog.delete();
        rfLog.delete();
        waitQ.push_back(w0);
        if (dbl) waitQ.push_back(w1);

        checks++;
        if (bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready: req_ready=%b, required 1", name, bus.req_ready);
        end
        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_addr   = addr;
        bus.req_freg   = freg;
        bus.st_data_lo = lo;
        bus.st_data_hi = hi;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'($urandom);
        bus.req_addr   = $urandom;
        bus.req_freg   = 5'($urandom);
        bus.st_data_lo = $urandom;
        bus.st_data_hi = $urandom;

        seen   = 1'b0;
        lat    = 0;
        gotErr = 1'b0;
        for (int k = 1; k <= 60 && !seen; k++) begin
            if (k > 1) @(negedge clk);
            if (bus.done === 1'b1) begin
                seen   = 1'b1;
                lat    = k;
                gotErr = bus.err;
            end
        end

        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done: no done within 60 cycles, required done", name);
        end
        checks++;
        if (gotErr !== bad) begin
            errors++;
            $display("FAIL %s err: err=%b, required %b", name, gotErr, bad);
        end
        checks++;
        if (lat != expLat) begin
            errors++;
            $display("FAIL %s latency: %0d cycles, required %0d", name, lat, expLat);
        end
        checks++;
        if (accLog.size() != expAcc.size()) begin
            errors++;
            $display("FAIL %s access_count: %0d, required %0d",
                     name, accLog.size(), expAcc.size());
        end
        n = (accLog.size() < expAcc.size()) ? accLog.size() : expAcc.size();
        for (int i = 0; i < n; i++) begin
            checks++;
            if (accLog[i].addr !== expAcc[i].addr || accLog[i].we !== expAcc[i].we ||
                (expAcc[i].we && accLog[i].wdata !== expAcc[i].wdata)) begin
                errors++;
                $display("FAIL %s access%0d: addr=%h we=%b wdata=%h, required %h %b %h",
                         name, i, accLog[i].addr, accLog[i].we, accLog[i].wdata,
                         expAcc[i].addr, expAcc[i].we, expAcc[i].wdata);
            end
        end
        checks++;
        if (rfLog.size() != ((!bad && !st) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s rf_count: %0d strobe cycles, required %0d",
                     name, rfLog.size(), (!bad && !st) ? 1 : 0);
        end else if (rfLog.size() == 1) begin
            checks++;
            if (rfLog[0].r !== freg || rfLog[0].d1 !== e0 || rfLog[0].dw !== dbl ||
                rfLog[0].d2 !== (dbl ? e1 : 32'd0)) begin
                errors++;
                $display("FAIL %s rf_write: reg=%0d d1=%h d2=%h dw=%b, required %0d %h %h %b",
                         name, rfLog[0].r, rfLog[0].d1, rfLog[0].d2, rfLog[0].dw,
                         freg, e0, dbl ? e1 : 32'd0, dbl);
            end
        end

        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s after_done: done=%b req_ready=%b, required 0 1",
                     name, bus.done, bus.req_ready);
        end
    endtask

    task automatic test_reset();
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_addr   = 32'd0;
        bus.req_freg   = 5'd0;
        bus.st_data_lo = 32'd0;
        bus.st_data_hi = 32'd0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b, required 0", bus.req_ready);
        end
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.done, bus.err, bus.rf_reg_write,
             bus.rf_reg_dwrite, bus.mem_addr, bus.mem_wdata, bus.rf_write_reg,
             bus.rf_wdata1, bus.rf_wdata2} !== 170'd0) begin
            errors++;
            $display("FAIL reset_outputs: mem_req=%b we=%b done=%b err=%b addr=%h, required all 0",
                     bus.mem_req, bus.mem_we, bus.done, bus.err, bus.mem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.mem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: req_ready=%b mem_req=%b, required 1 0",
                     bus.req_ready, bus.mem_req);
        end
    endtask

    task automatic test_lwc1();
        memArr[32'h100] = 32'h3F80_0000;
        runReq("lwc1", 2'b00, 32'h100, 5'd5, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic test_ldc1_wait();
        runReq("ldc1_wait", 2'b01, 32'h208, 5'd4, 32'h0, 32'h0, 2, 0);
    endtask

    task automatic test_sdc1();
        runReq("sdc1", 2'b11, 32'h40, 5'd2, 32'hAAAA_5555, 32'h1234_5678, 0, 0);
        checks++;
        if (memArr[32'h40] !== 32'hAAAA_5555 || memArr[32'h44] !== 32'h1234_5678) begin
            errors++;
            $display("FAIL sdc1_mem: [40]=%h [44]=%h, required aaaa5555 12345678",
                     memArr[32'h40], memArr[32'h44]);
        end
    endtask

    task automatic test_rejects();
        runReq("rej_ldc1_f31", 2'b01, 32'h200, 5'd31, 32'h0, 32'h0, 0, 0);
        runReq("rej_swc1_mis", 2'b10, 32'h102, 5'd1, 32'h5, 32'h6, 0, 0);
        runReq("rej_sdc1_mis", 2'b11, 32'h104, 5'd2, 32'h5, 32'h6, 0, 0);
    endtask

    task automatic test_double_wrap();
        runReq("ldc1_top", 2'b01, 32'hFFFF_FFF8, 5'd30, 32'h0, 32'h0, 1, 1);
    endtask

    task automatic test_reset_mid_access();
        bit inAcc1;
        waitQ.delete();
        accLog.delete();
        rfLog.delete();
        waitQ.push_back(0);
        waitQ.push_back(5);
        bus.req_valid = 1'b1;
        bus.req_op    = 2'b01;
        bus.req_addr  = 32'h300;
        bus.req_freg  = 5'd6;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        inAcc1 = 1'b0;
        for (int k = 0; k < 20 && !inAcc1; k++) begin
            if (accLog.size() == 1 && bus.mem_req === 1'b1) inAcc1 = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!inAcc1) begin
            errors++;
            $display("FAIL rst_mid_reach: second access not seen, required in progress");
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.mem_req !== 1'b0 || bus.req_ready !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_drop: mem_req=%b req_ready=%b done=%b, required 0 0 0",
                     bus.mem_req, bus.req_ready, bus.done);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        waitQ.delete();
        @(negedge clk);
        checks++;
        if (bus.req_ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_release: req_ready=%b done=%b, required 1 0",
                     bus.req_ready, bus.done);
        end
        checks++;
        if (rfLog.size() != 0) begin
            errors++;
            $display("FAIL rst_mid_rf: %0d strobe cycles, required 0", rfLog.size());
        end
        runReq("rst_mid_lwc1", 2'b00, 32'h404, 5'd9, 32'h0, 32'h0, 0, 0);
    endtask

    task automatic test_back_to_back();
        logic [1:0]  op;
        logic [31:0] addr;
        logic [4:0]  freg;
        for (int i = 0; i < 40; i++) begin
            op   = 2'($urandom_range(0, 3));
            addr = {19'd0, 10'($urandom_range(0, 1023)), 3'b000};
            if ($urandom_range(0, 7) == 0) addr = addr + 32'($urandom_range(1, 7));
            else if (!op[0] && $urandom_range(0, 1) == 1) addr = addr + 32'd4;
            freg = 5'($urandom_range(0, 31));
            if (op[0] && $urandom_range(0, 7) != 0) freg[0] = 1'b0;
            runReq("rand", op, addr, freg, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_lwc1();
        test_ldc1_wait();
        test_sdc1();
        test_rejects();
        test_double_wrap();
        test_reset_mid_access();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fp_pair_mem_sequencer.md
# fp_pair_mem_sequencer

Sequences floating-point loads and stores (LWC1, LDC1, SWC1, SDC1) between the 32-bit data memory port and the 32x32 float register file. A double-precision access is split into two word accesses to the even/odd register pair. Loads end in a single-cycle regWrite or regDWrite into the register file. Stores take their data from the register file's dataOut1/dataOut1p1 read ports. The block sits between the MEM stage and the FP register file write port.

## Interface
- No parameters; widths fixed: data 32, address 32, register index 5.
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle and able to accept; request accepted on a rising edge with req_valid & req_ready
- req_op  in  2  00 LWC1, 01 LDC1, 10 SWC1, 11 SDC1
- req_addr  in  32  byte address
- req_freg  in  5  FP register index; the even register of the pair for doubles
- st_data_lo  in  32  store word for req_freg (register file dataOut1)
- st_data_hi  in  32  store word for req_freg+1 (register file dataOut1p1)
- mem_req, mem_we  out  1  memory access strobe, write enable
- mem_addr, mem_wdata  out  32  memory word address, write data
- mem_ack  in  1  memory completes the current access this cycle
- mem_rdata  in  32  read data; valid when mem_ack is high
- rf_write_reg  out  5  to register file writeReg
- rf_wdata1, rf_wdata2  out  32  to writeData1 and writeData2
- rf_reg_write, rf_reg_dwrite  out  1  to regWrite and regDWrite
- done  out  1  one-cycle completion pulse
- err  out  1  qualifies done; request rejected

## Operation
- Request checks at accept:
  - Single requests need req_addr[1:0]=0.
  - Double requests need req_addr[2:0]=0 and req_freg[0]=0.
  - A failing request goes to ERR. No memory access and no register write take place.
- On accept, latch op, address, freg, st_data_lo and st_data_hi. Later changes on these inputs are ignored.
- States and transitions:
  - IDLE: req_ready=1. A valid request goes to ACC0, or to ERR if it fails the checks.
  - ACC0: mem_req=1, mem_addr=addr, mem_we=store, mem_wdata=lo.
    - Waits for mem_ack; a load captures mem_rdata into lo.
    - Exit: double -> ACC1; single load -> WB; single store -> DONE.
  - ACC1: mem_req=1, mem_addr=addr+4 (mod 2^32), mem_wdata=hi. Waits for mem_ack; a load captures mem_rdata into hi. Exit: load -> WB, store -> DONE.
  - WB, one cycle:
    - rf_write_reg=freg, rf_wdata1=lo, rf_wdata2=hi.
    - rf_reg_write=1 for a single, rf_reg_dwrite=1 for a double; never both.
    - Next state is DONE.
  - DONE: done=1, err=0, one cycle; next state is IDLE.
  - ERR: done=1, err=1, one cycle; next state is IDLE.
- While mem_req is high, mem_addr, mem_we and mem_wdata are held stable until mem_ack. mem_ack is ignored when mem_req=0.
- A load to f0 still runs fully. Dropping the write is the register file's job.
- rf_wdata2 is 0 for single loads.

## Timing
- All outputs are registered or decoded from state only, with no combinational path from inputs to outputs. The exception is req_ready = (state==IDLE) & rst_n.
- Reset, asynchronous: state IDLE; done=err=mem_req=mem_we=rf_reg_write=rf_reg_dwrite=0; mem_addr, mem_wdata, rf_write_reg, rf_wdata1 and rf_wdata2 all 0; req_ready=0 while rst_n is low.
- Reset in the middle of an access drops mem_req immediately. No register-file write follows, and no done is issued.
- Latency from the accept edge to done high, with zero-wait memory (mem_ack in the first cycle of mem_req):
  - SWC1: 2 cycles.
  - LWC1: 3 cycles.
  - SDC1: 3 cycles.
  - LDC1: 4 cycles.
  - ERR: 1 cycle.
- Each cycle mem_ack stays low adds one cycle.
- The next request can be accepted in the cycle after done.
- rf_reg_write and rf_reg_dwrite are held stable for the whole WB cycle. This matches the register file's clock-high write window.

## Test plan
- LWC1: addr 0x100, freg 5, mem_rdata 0x3F800000 with zero wait. Required: one mem_req cycle with we=0 and addr 0x100; WB with rf_write_reg=5, rf_wdata1=0x3F800000 and rf_reg_write=1; done 3 cycles after accept, err=0.
- LDC1: addr 0x208, freg 4, with 2 wait states on the first word only. Required: accesses to 0x208 then 0x20C; WB with rf_reg_dwrite=1, rf_wdata1 = first word and rf_wdata2 = second word; done 6 cycles after accept.
- SDC1: freg 2, lo 0xAAAA5555, hi 0x12345678, addr 0x40. Inputs change after accept. Required: write 0xAAAA5555 to 0x40 and 0x12345678 to 0x44 using the latched values; no rf strobe; done after 3 cycles.
- Rejects: LDC1 with freg 31, then SWC1 with addr 0x102. Required: each gives done=1 and err=1 one cycle after accept, with no mem_req and no rf strobe.
- Reset: drop rst_n while LDC1 is in ACC1. Required: mem_req low immediately, no rf strobe; after release req_ready=1 and a following LWC1 completes normally.
